// File: rtl/lsu_pkg.sv
// lsu_pkg: shared types for the load/store unit.
//   size_e  - access size code, same encoding the decoder emits
//   state_e - access FSM states
package lsu_pkg;

   typedef enum logic [1:0] {
      SZ_NONE = 2'b00,
      SZ_WORD = 2'b01,
      SZ_HALF = 2'b10,
      SZ_BYTE = 2'b11
   } size_e;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      REQ  = 2'b01,
      DONE = 2'b10
   } state_e;

endpackage

// File: rtl/lsu_align.sv
// lsu_align: combinational lane steering for one access.
//   i_size/i_addr_lo/i_unsigned - access shape
//   i_wdata  - right-aligned store data   -> o_wdata_rep (lane-replicated)
//   i_rdata  - raw memory word            -> o_rdata_ext (selected lane, extended)
//   o_be     - byte enables, bit k = lane k
//   o_misaligned - half on odd address or word not on a word boundary
module lsu_align
   import lsu_pkg::*;
(
   input  size_e       i_size,
   input  logic [1:0]  i_addr_lo,
   input  logic        i_unsigned,
   input  logic [31:0] i_wdata,
   input  logic [31:0] i_rdata,
   output logic [3:0]  o_be,
   output logic [31:0] o_wdata_rep,
   output logic [31:0] o_rdata_ext,
   output logic        o_misaligned
);

   logic [7:0]  w_byte;
   logic [15:0] w_half;

   always_comb begin
      o_be         = 4'b0000;
      o_wdata_rep  = i_wdata;
      o_rdata_ext  = i_rdata;
      o_misaligned = 1'b0;
      w_byte       = 8'h00;
      w_half       = 16'h0000;
      case (i_size)
         SZ_BYTE: begin
            o_be        = 4'b0001 << i_addr_lo;
            o_wdata_rep = {4{i_wdata[7:0]}};
            case (i_addr_lo)
               2'd0:    w_byte = i_rdata[7:0];
               2'd1:    w_byte = i_rdata[15:8];
               2'd2:    w_byte = i_rdata[23:16];
               default: w_byte = i_rdata[31:24];
            endcase
            o_rdata_ext = {{24{w_byte[7] & ~i_unsigned}}, w_byte};
         end
         SZ_HALF: begin
            o_be         = i_addr_lo[1] ? 4'b1100 : 4'b0011;
            o_wdata_rep  = {2{i_wdata[15:0]}};
            w_half       = i_addr_lo[1] ? i_rdata[31:16] : i_rdata[15:0];
            o_rdata_ext  = {{16{w_half[15] & ~i_unsigned}}, w_half};
            o_misaligned = i_addr_lo[0];
         end
         SZ_WORD: begin
            o_be         = 4'b1111;
            o_misaligned = (i_addr_lo != 2'b00);
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/load_store_unit.sv
// load_store_unit: performs decoder-requested loads/stores on a word-wide
// data memory over a req/ack handshake, stalling the core meanwhile.
//   clk, rst            - clock, synchronous active-high reset
//   load_size_i, store_size_i, unsigned_i, addr_i, wdata_i - access from core
//   stall_o, rdata_o, done_o, err_o                         - status to core
//   mem_req_o, mem_we_o, mem_addr_o, mem_be_o, mem_wdata_o,
//   mem_ack_i, mem_rdata_i                                  - memory port
module load_store_unit
   import lsu_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 16
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [1:0]  load_size_i,
   input  logic [1:0]  store_size_i,
   input  logic        unsigned_i,
   input  logic [31:0] addr_i,
   input  logic [31:0] wdata_i,
   output logic        stall_o,
   output logic [31:0] rdata_o,
   output logic        done_o,
   output logic        err_o,
   output logic        mem_req_o,
   output logic        mem_we_o,
   output logic [31:0] mem_addr_o,
   output logic [3:0]  mem_be_o,
   output logic [31:0] mem_wdata_o,
   input  logic        mem_ack_i,
   input  logic [31:0] mem_rdata_i
);

   localparam int             CW       = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [CW-1:0]  WAIT_MAX = CW'(TIMEOUT_CYCLES - 1);

   state_e        r_state, w_next;
   size_e         r_size;
   logic [1:0]    r_addr_lo;
   logic          r_unsigned;
   logic          r_we;
   logic [3:0]    r_be;
   logic [31:0]   r_addr, r_wdata, r_rdata;
   logic          r_err;
   logic [CW-1:0] r_wait;

   logic          w_is_store, w_active, w_go, w_timeout;
   size_e         w_size, w_al_size;
   logic [1:0]    w_al_addr_lo;
   logic          w_al_unsigned;
   logic [3:0]    w_be;
   logic [31:0]   w_wdata_rep, w_rdata_ext;
   logic          w_misaligned;

   // a store wins over a simultaneous load
   assign w_is_store = (store_size_i != 2'b00);
   assign w_size     = w_is_store ? size_e'(store_size_i) : size_e'(load_size_i);
   assign w_active   = (w_size != SZ_NONE);

   // Aligner looks at live inputs while deciding to issue, and at the
   // latched access once issued, so extension is immune to input drift.
   assign w_al_size     = (r_state == IDLE) ? w_size       : r_size;
   assign w_al_addr_lo  = (r_state == IDLE) ? addr_i[1:0]  : r_addr_lo;
   assign w_al_unsigned = (r_state == IDLE) ? unsigned_i   : r_unsigned;

   lsu_align u_align (
      .i_size       (w_al_size),
      .i_addr_lo    (w_al_addr_lo),
      .i_unsigned   (w_al_unsigned),
      .i_wdata      (wdata_i),
      .i_rdata      (mem_rdata_i),
      .o_be         (w_be),
      .o_wdata_rep  (w_wdata_rep),
      .o_rdata_ext  (w_rdata_ext),
      .o_misaligned (w_misaligned)
   );

   assign w_go      = (r_state == IDLE) && w_active && !w_misaligned;
   assign w_timeout = (r_wait == WAIT_MAX);

   always_ff @(posedge clk) begin
      if (rst) r_state <= IDLE;
      else     r_state <= w_next;
   end

   always_comb begin
      w_next    = r_state;
      stall_o   = 1'b0;
      err_o     = 1'b0;
      done_o    = 1'b0;
      mem_req_o = 1'b0;
      case (r_state)
         IDLE: begin
            if (w_active && w_misaligned) begin
               err_o = 1'b1;
            end else if (w_active) begin
               stall_o = 1'b1;
               w_next  = REQ;
            end
         end
         REQ: begin
            stall_o   = 1'b1;
            mem_req_o = 1'b1;
            // ack is checked first so an ack in the final cycle beats timeout
            if (mem_ack_i || w_timeout) w_next = DONE;
         end
         DONE: begin
            done_o = 1'b1;
            err_o  = r_err;
            w_next = IDLE;
         end
         default: w_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_size     <= SZ_NONE;
         r_addr_lo  <= 2'b00;
         r_unsigned <= 1'b0;
         r_we       <= 1'b0;
         r_be       <= 4'b0000;
         r_addr     <= 32'h0;
         r_wdata    <= 32'h0;
         r_rdata    <= 32'h0;
         r_err      <= 1'b0;
         r_wait     <= '0;
      end else begin
         case (r_state)
            IDLE: begin
               if (w_go) begin
                  r_size     <= w_size;
                  r_addr_lo  <= addr_i[1:0];
                  r_unsigned <= unsigned_i;
                  r_we       <= w_is_store;
                  r_be       <= w_be;
                  r_addr     <= {addr_i[31:2], 2'b00};
                  r_wdata    <= w_wdata_rep;
                  r_err      <= 1'b0;
                  r_wait     <= '0;
               end
            end
            REQ: begin
               if (r_wait != WAIT_MAX) r_wait <= r_wait + 1'b1;
               if (mem_ack_i) begin
                  r_rdata <= r_we ? 32'h0 : w_rdata_ext;
               end else if (w_timeout) begin
                  r_rdata <= 32'h0;
                  r_err   <= 1'b1;
               end
            end
            DONE: begin
               r_rdata <= 32'h0;
               r_err   <= 1'b0;
            end
            default: ;
         endcase
      end
   end

   assign rdata_o     = r_rdata;
   assign mem_we_o    = r_we;
   assign mem_be_o    = r_be;
   assign mem_addr_o  = r_addr;
   assign mem_wdata_o = r_wdata;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: table of single accesses with a
// scripted ack delay, plus hand sequences for misalignment and reset.
module tb_load_store_unit;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [1:0]  load_size_i = 2'b00, store_size_i = 2'b00;
   logic        unsigned_i = 1'b0;
   logic [31:0] addr_i = '0, wdata_i = '0;
   logic        stall_o, done_o, err_o;
   logic [31:0] rdata_o;
   logic        mem_req_o, mem_we_o;
   logic [31:0] mem_addr_o, mem_wdata_o;
   logic [3:0]  mem_be_o;
   logic        mem_ack_i = 1'b0;
   logic [31:0] mem_rdata_i = '0;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   load_store_unit #(.TIMEOUT_CYCLES(16)) dut (
      .clk(clk), .rst(rst),
      .load_size_i(load_size_i), .store_size_i(store_size_i),
      .unsigned_i(unsigned_i), .addr_i(addr_i), .wdata_i(wdata_i),
      .stall_o(stall_o), .rdata_o(rdata_o), .done_o(done_o), .err_o(err_o),
      .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
      .mem_be_o(mem_be_o), .mem_wdata_o(mem_wdata_o),
      .mem_ack_i(mem_ack_i), .mem_rdata_i(mem_rdata_i)
   );

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h", nm, act, exp);
      end
   endtask

   typedef struct {
      logic [1:0]  ld, st;
      logic        uns;
      logic [31:0] addr, wd, rd;
      int          ack_after;   // REQ cycles before ack; -1 = never
      logic [31:0] e_addr;
      logic [3:0]  e_be;
      logic [31:0] e_wd;
      logic        e_we;
      logic [31:0] e_rdata;
      logic        e_err;
      int          e_stall, e_req;
   } vec_t;

   // Runs one access starting in IDLE; samples on negedges.
   task automatic do_access(input vec_t v, output int n_stall, output int n_req,
                            output int n_done, output logic [31:0] f_addr,
                            output logic [31:0] f_wd, output logic [3:0] f_be,
                            output logic f_we, output logic [31:0] d_rdata,
                            output logic d_err);
      bit done_seen = 0;
      int post = 0;
      n_stall = 0; n_req = 0; n_done = 0;
      f_addr = 'x; f_wd = 'x; f_be = 'x; f_we = 'x; d_rdata = 'x; d_err = 'x;
      @(posedge clk); #1;
      load_size_i = v.ld; store_size_i = v.st; unsigned_i = v.uns;
      addr_i = v.addr; wdata_i = v.wd; mem_rdata_i = v.rd;
      for (int c = 0; c < 60; c++) begin
         @(negedge clk);
         if (stall_o) n_stall++;
         if (mem_req_o) begin
            n_req++;
            if (n_req == 1) begin
               f_addr = mem_addr_o; f_wd = mem_wdata_o; f_be = mem_be_o; f_we = mem_we_o;
            end
         end
         mem_ack_i = mem_req_o && (v.ack_after >= 0) && (n_req == v.ack_after + 1);
         if (done_o) begin
            n_done++;
            d_rdata = rdata_o; d_err = err_o;
            load_size_i = 2'b00; store_size_i = 2'b00;
            done_seen = 1;
         end else if (done_seen) begin
            post++;
            if (post == 2) break;
         end
      end
      mem_ack_i = 1'b0;
      load_size_i = 2'b00; store_size_i = 2'b00;
   endtask

   vec_t vecs [12];

   initial begin
      int n_stall, n_req, n_done, cnt;
      logic [31:0] f_addr, f_wd, d_rdata;
      logic [3:0]  f_be;
      logic        f_we, d_err;
      string       tag;

      //            ld     st     uns addr          wd            rd            ack e_addr        e_be     e_wd          we e_rdata       err st rq
      vecs[0]  = '{2'b00, 2'b11, 0, 32'h0000_1003, 32'h0000_00A5, 32'h0,         1, 32'h0000_1000, 4'b1000, 32'hA5A5_A5A5, 1, 32'h0,         0, 3, 2};
      vecs[1]  = '{2'b10, 2'b00, 0, 32'h0000_2002, 32'h0,         32'h8001_7FFF, 0, 32'h0000_2000, 4'b1100, 32'h0,         0, 32'hFFFF_8001, 0, 2, 1};
      vecs[2]  = '{2'b10, 2'b00, 0, 32'h0000_2000, 32'h0,         32'h8001_7FFF, 0, 32'h0000_2000, 4'b0011, 32'h0,         0, 32'h0000_7FFF, 0, 2, 1};
      vecs[3]  = '{2'b10, 2'b00, 1, 32'h0000_2002, 32'h0,         32'h8001_7FFF, 0, 32'h0000_2000, 4'b1100, 32'h0,         0, 32'h0000_8001, 0, 2, 1};
      vecs[4]  = '{2'b11, 2'b00, 0, 32'h0000_0000, 32'h0,         32'h1234_5680, 0, 32'h0000_0000, 4'b0001, 32'h0,         0, 32'hFFFF_FF80, 0, 2, 1};
      vecs[5]  = '{2'b00, 2'b10, 0, 32'h0000_0006, 32'h0000_BEEF, 32'h0,         0, 32'h0000_0004, 4'b1100, 32'hBEEF_BEEF, 1, 32'h0,         0, 2, 1};
      vecs[6]  = '{2'b11, 2'b00, 1, 32'h0000_0002, 32'h0,         32'h1234_5680, 0, 32'h0000_0000, 4'b0100, 32'h0,         0, 32'h0000_0034, 0, 2, 1};
      vecs[7]  = '{2'b00, 2'b01, 0, 32'h0000_0010, 32'hDEAD_BEEF, 32'h0,         0, 32'h0000_0010, 4'b1111, 32'hDEAD_BEEF, 1, 32'h0,         0, 2, 1};
      vecs[8]  = '{2'b01, 2'b11, 0, 32'h0000_0021, 32'h0000_005A, 32'hFFFF_FFFF, 0, 32'h0000_0020, 4'b0010, 32'h5A5A_5A5A, 1, 32'h0,         0, 2, 1};
      vecs[9]  = '{2'b01, 2'b00, 0, 32'h0000_0030, 32'h0,         32'hCAFE_F00D, 3, 32'h0000_0030, 4'b1111, 32'h0,         0, 32'hCAFE_F00D, 0, 5, 4};
      vecs[10] = '{2'b01, 2'b00, 0, 32'h0000_0040, 32'h0,         32'h5555_5555,-1, 32'h0000_0040, 4'b1111, 32'h0,         0, 32'h0,         1, 17, 16};
      vecs[11] = '{2'b01, 2'b00, 0, 32'h0000_0040, 32'h0,         32'h1122_3344,15, 32'h0000_0040, 4'b1111, 32'h0,         0, 32'h1122_3344, 0, 17, 16};

      // reset state
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_req",   32'(mem_req_o), 32'd0);
      chk("rst_we",    32'(mem_we_o),  32'd0);
      chk("rst_done",  32'(done_o),    32'd0);
      chk("rst_err",   32'(err_o),     32'd0);
      chk("rst_stall", 32'(stall_o),   32'd0);
      chk("rst_be",    32'(mem_be_o),  32'd0);
      chk("rst_addr",  mem_addr_o,     32'd0);
      chk("rst_wd",    mem_wdata_o,    32'd0);
      chk("rst_rdata", rdata_o,        32'd0);
      rst = 1'b0;

      foreach (vecs[i]) begin
         do_access(vecs[i], n_stall, n_req, n_done, f_addr, f_wd, f_be, f_we, d_rdata, d_err);
         tag = $sformatf("v%0d", i);
         chk({tag, "_addr"},  f_addr,         vecs[i].e_addr);
         chk({tag, "_be"},    32'(f_be),      32'(vecs[i].e_be));
         chk({tag, "_wd"},    f_wd,           vecs[i].e_wd);
         chk({tag, "_we"},    32'(f_we),      32'(vecs[i].e_we));
         chk({tag, "_rdata"}, d_rdata,        vecs[i].e_rdata);
         chk({tag, "_err"},   32'(d_err),     32'(vecs[i].e_err));
         chk({tag, "_stall"}, 32'(n_stall),   32'(vecs[i].e_stall));
         chk({tag, "_req"},   32'(n_req),     32'(vecs[i].e_req));
         chk({tag, "_done"},  32'(n_done),    32'd1);
      end

      // misaligned word load: immediate error, never a request
      @(posedge clk); #1;
      load_size_i = 2'b01; addr_i = 32'h0000_4002;
      @(negedge clk);
      chk("mis_err",   32'(err_o),   32'd1);
      chk("mis_stall", 32'(stall_o), 32'd0);
      cnt = 0;
      for (int c = 0; c < 4; c++) begin
         if (mem_req_o || done_o) cnt++;
         @(negedge clk);
      end
      chk("mis_noreq", 32'(cnt), 32'd0);
      load_size_i = 2'b00; addr_i = '0;

      // reset in the second REQ cycle
      @(posedge clk); #1;
      load_size_i = 2'b01; addr_i = 32'h0000_0050;
      @(negedge clk);
      chk("rr_idle_stall", 32'(stall_o), 32'd1);
      @(negedge clk);
      chk("rr_req1", 32'(mem_req_o), 32'd1);
      @(negedge clk);
      chk("rr_req2", 32'(mem_req_o), 32'd1);
      rst = 1'b1;
      @(posedge clk); #1;
      chk("rr_req_low", 32'(mem_req_o), 32'd0);
      chk("rr_nodone",  32'(done_o),    32'd0);
      load_size_i = 2'b00; addr_i = '0;
      rst = 1'b0;
      cnt = 0;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         if (done_o || mem_req_o) cnt++;
      end
      chk("rr_quiet", 32'(cnt), 32'd0);
      begin
         vec_t s;
         s = '{2'b00, 2'b01, 0, 32'h0, 32'h0BAD_F00D, 32'h0, 0, 32'h0, 4'b1111, 32'h0BAD_F00D, 1, 32'h0, 0, 2, 1};
         do_access(s, n_stall, n_req, n_done, f_addr, f_wd, f_be, f_we, d_rdata, d_err);
         chk("rr_st_be",   32'(f_be),    32'hF);
         chk("rr_st_wd",   f_wd,         32'h0BAD_F00D);
         chk("rr_st_we",   32'(f_we),    32'd1);
         chk("rr_st_done", 32'(n_done),  32'd1);
         chk("rr_st_err",  32'(d_err),   32'd0);
         chk("rr_st_req",  32'(n_req),   32'd1);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/load_store_unit.md
# load_store_unit

Data-side counterpart of the instruction decoder. It consumes the decoder's load-size and store-size codes plus the ALU-computed address. It then performs the access on a word-wide data memory over a request/acknowledge handshake, handling byte enables, lane alignment and load sign/zero extension. While an access is outstanding it stalls the core.

## Interface
- `TIMEOUT_CYCLES`, 16: cycles in REQ without `mem_ack_i` before the access is aborted with an error.
- `clk` input 1: clock, rising edge.
- `rst` input 1: synchronous, active-high reset.
- `load_size_i` input 2: 00 none, 01 word, 10 half, 11 byte.
- `store_size_i` input 2: same encoding as `load_size_i`.
- `unsigned_i` input 1: 1 = zero-extend loads (funct3[2]).
- `addr_i` input 32: byte address.
- `wdata_i` input 32: store data, right-aligned.
- `stall_o` output 1: core must hold PC and all inputs stable.
- `rdata_o` output 32: extended load result; valid while `done_o`=1.
- `done_o` output 1: one-cycle completion pulse.
- `err_o` output 1: one-cycle pulse; misaligned access or timeout.
- `mem_req_o` output 1: memory request.
- `mem_we_o` output 1: 1 = write.
- `mem_addr_o` output 32: word address, with {addr_i[31:2],2'b00}.
- `mem_be_o` output 4: byte enables; bit k = byte lane k.
- `mem_wdata_o` output 32: lane-replicated store data.
- `mem_ack_i` input 1: access complete; read data valid.
- `mem_rdata_i` input 32: read word.

## Operation
- An access is active when either size input is nonzero. If both are nonzero, the store is performed and the load is ignored.
- Misaligned access: half with addr[0]=1, or word with addr[1:0]≠00. It issues no memory request. In IDLE, `err_o`=1 and `stall_o`=0 combinationally, with no state change.
- FSM states and transitions:
  - IDLE: an aligned active access → REQ. `stall_o`=1 combinationally in the same cycle.
  - REQ: `mem_req_o`=1, and `stall_o`=1. The address, enables, data and `mem_we_o` are registered at IDLE exit and are constant throughout REQ.
    - `mem_req_o`&&`mem_ack_i` → DONE, capturing `mem_rdata_i`.
    - If the wait counter reaches TIMEOUT_CYCLES-1 without ack → DONE with error flagged.
  - DONE: `stall_o`=0, `done_o`=1, and `err_o` = timeout flag. The next state is always IDLE.
    - DONE never re-issues, even though the inputs still show the same instruction.
- Store byte enables:
  - Byte: `mem_be_o` = 1<<addr[1:0], with `wdata_i[7:0]` replicated ×4.
  - Half: 0011 (addr[1]=0) or 1100 (addr[1]=1), with `wdata_i[15:0]` replicated ×2.
  - Word: 1111, with `wdata_i`.
- Loads: `mem_we_o`=0 and `mem_be_o` = the same pattern as stores.
  - Byte: result = lane addr[1:0] of `mem_rdata_i`.
  - Half: result = half addr[1].
  - Sign-extend unless `unsigned_i`; word passes through.
- Stores and errored accesses give `rdata_o`=0.
- The wait counter is cleared on entry to REQ and saturates.

## Timing
- Reset values:
  - State IDLE.
  - `mem_req_o`, `mem_we_o`, `done_o`, `err_o` = 0.
  - `mem_be_o`=0, `mem_addr_o`=0, `mem_wdata_o`=0.
  - `rdata_o`=0, and `stall_o`=0 when the inputs are idle.
- Latency: with ack in the first REQ cycle, the access occupies 3 cycles (IDLE, REQ, DONE), i.e. the core stalls 2 cycles. Each extra wait cycle adds one.
- `mem_ack_i` is ignored outside REQ.
- `rst` in REQ or DONE: IDLE at the next edge, with `mem_req_o` low from that edge. The aborted access produces no `done_o`.
- A timeout with ack arriving in the same final cycle counts as success; ack wins.

## Structure
- `lsu_pkg` holds:
  - Size enum: SZ_NONE=00, SZ_WORD=01, SZ_HALF=10, SZ_BYTE=11. The decoder shares this encoding.
  - FSM state enum: IDLE, REQ, DONE.
- One combinational sub-module, `lsu_align`, takes size, addr[1:0], `unsigned_i`, wdata and rdata. It produces `be`, the replicated wdata, the extended rdata and the misaligned flag.
- The FSM, counter and registers live in the top module.

## Test plan
- Store byte: `wdata_i`=0x000000A5 at addr 0x1003, ack after 2 cycles.
  - Expect `mem_be_o`=1000, `mem_wdata_o`=0xA5A5A5A5, `mem_addr_o`=0x1000, `mem_we_o`=1.
  - Expect `stall_o` high for 3 cycles, then `done_o` pulse.
- Load half signed: `mem_rdata_i`=0x8001_7FFF.
  - addr 0x2002 → `rdata_o`=0xFFFF8001.
  - addr 0x2000 → 0x00007FFF.
  - addr 0x2002 with `unsigned_i`=1 → 0x00008001.
- Load byte, `mem_rdata_i`=0x12345680 at addr 0x0 with immediate ack.
  - Expect `rdata_o`=0xFFFFFF80, `be`=0001.
  - Expect 3-cycle access and `done_o` exactly once.
- Misaligned word load at 0x4002 → `err_o`=1, `stall_o`=0 in the same cycle, and `mem_req_o` never asserts.
- Timeout: word load with `mem_ack_i` held 0.
  - Expect `mem_req_o` high for exactly 16 cycles, then `done_o`=1, `err_o`=1, `rdata_o`=0.
  - A repeat with ack on the 16th cycle succeeds with `err_o`=0.
- Reset on the second REQ cycle: `mem_req_o`=0 at the next edge, state IDLE, no `done_o`. The following store at 0x0 completes normally.
